// File: rtl/cp0_exception_unit.sv
// Coprocessor 0 for the P7 pipelined MIPS CPU: SR/Cause/EPC, exception/interrupt request, mfc0/mtc0, eret.
// Optional PRId register (read-only, register 15) enabled by defining CP0_PRID_EN.
module cp0_exception_unit #(
  parameter int HWINT_W = 6
`ifdef CP0_PRID_EN
  , parameter logic [31:0] PRID_VALUE = 32'h2022_0007
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        DIn,
  input  logic               WE,
  input  logic [31:0]        PC,
  input  logic               BDIn,
  input  logic [4:0]         ExcCodeIn,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXLClr,
  output logic               Req,
  output logic [31:0]        EPCOut,
  output logic [31:0]        DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
`ifdef CP0_PRID_EN
  localparam logic [4:0] REG_PRID  = 5'd15;
`endif

  // SR fields
  logic [HWINT_W-1:0] im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  // Cause fields
  logic               bd_q, bd_d;
  logic [HWINT_W-1:0] ip_q, ip_d;
  logic [4:0]         exc_code_q, exc_code_d;
  // EPC
  logic [31:0]        epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        sr_we;
  logic        epc_we;
  logic [31:0] victim_pc;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;

  // PC[1:0] is dropped by word alignment; unimplemented SR bits are discarded on write.
  logic unused_bits;
  assign unused_bits = ^{PC[1:0], DIn[31:10+HWINT_W], DIn[9:2]};

  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
  assign Req     = (int_req | exc_req) & ~reset;

  assign sr_we  = WE & ~Req & (A2 == REG_SR);
  assign epc_we = WE & ~Req & (A2 == REG_EPC);

  // A victim in a delay slot must restart at its branch, one word earlier.
  assign victim_pc = {PC[31:2], 2'b00} - (BDIn ? 32'd4 : 32'd0);

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (Req) begin
      exl_d      = 1'b1;
      bd_d       = BDIn;
      exc_code_d = int_req ? 5'd0 : ExcCodeIn;
      epc_d      = victim_pc;
    end else begin
      if (sr_we) begin
        im_d  = DIn[10 +: HWINT_W];
        exl_d = DIn[1];
        ie_d  = DIn[0];
      end
      if (epc_we) begin
        epc_d = DIn;
      end
      // eret after the SR write so a same-cycle mtc0 cannot re-set EXL.
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    sr_rd                  = 32'd0;
    sr_rd[10 +: HWINT_W]   = im_q;
    sr_rd[1]               = exl_q;
    sr_rd[0]               = ie_q;

    cause_rd               = 32'd0;
    cause_rd[31]           = bd_q;
    cause_rd[10 +: HWINT_W] = ip_q;
    cause_rd[6:2]          = exc_code_q;
  end

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = sr_rd;
      REG_CAUSE: DOut = cause_rd;
      REG_EPC:   DOut = epc_q;
`ifdef CP0_PRID_EN
      REG_PRID:  DOut = PRID_VALUE;
`endif
      default:   DOut = 32'd0;
    endcase
  end

  assign EPCOut = epc_q;

endmodule
